// File: rtl/dibu_code_loader.sv
// dibu_code_loader: loads a checksummed byte-stream program image into code memory
// and releases run only after a verified load.
module dibu_code_loader #(
    parameter int CODE_W  = 16,
    parameter int CODE_AW = 8,
    parameter int DEPTH   = 256,
    parameter int AUTORUN = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_req,
    input  logic               load_valid,
    input  logic [7:0]         load_byte,
    output logic               load_ready,
    output logic               run,
    output logic               code_w_en,
    output logic [CODE_AW-1:0] code_addr_in,
    output logic [CODE_W-1:0]  code_in,
    output logic               busy,
    output logic               done,
    output logic               error
);
    localparam int BPW = CODE_W / 8;

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

    state_t              state_q, state_d;
    logic [7:0]          len_q, len_d, wcnt_q, wcnt_d, bc_q, bc_d, sum_q, sum_d;
    logic [CODE_AW-1:0]  addr_q, addr_d, caddr_q, caddr_d;
    logic [CODE_W-1:0]   word_q, word_d, code_q, code_d;
    logic                wen_q, wen_d, run_q, run_d, done_q, done_d;
    logic                err_q, err_d, busy_q, busy_d;
    logic                hs;
    logic [CODE_W-1:0]   word_nx;
    logic [7:0]          sum_nx;

    always_comb begin
        load_ready = (state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM) && !load_req;
        hs      = load_valid && load_ready;
        word_nx = (word_q << 8) | CODE_W'(load_byte);
        sum_nx  = sum_q + load_byte;
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        bc_d    = bc_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        caddr_d = caddr_q;
        word_d  = word_q;
        code_d  = code_q;
        wen_d   = 1'b0;
        if (load_req) begin
            state_d = S_LEN;
            addr_d  = '0;
            wcnt_d  = '0;
            bc_d    = '0;
            sum_d   = '0;
        end else if (hs) begin
            sum_d = sum_nx;
            case (state_q)
                S_LEN: begin
                    len_d   = load_byte;
                    state_d = (load_byte == 8'd0 || int'(load_byte) > DEPTH) ? S_ERR : S_DATA;
                end
                S_DATA: begin
                    word_d = word_nx;
                    bc_d   = bc_q + 8'd1;
                    if (bc_q == 8'(BPW - 1)) begin
                        bc_d    = '0;
                        wen_d   = 1'b1;
                        code_d  = word_nx;
                        caddr_d = addr_q;
                        addr_d  = addr_q + CODE_AW'(1);
                        wcnt_d  = wcnt_q + 8'd1;
                        if (wcnt_q + 8'd1 == len_q)
                            state_d = S_CSUM;
                    end
                end
                S_CSUM: state_d = (sum_nx == 8'd0) ? S_RUN : S_ERR;
                default: ;
            endcase
        end
        // Status flags are registered from the next state so they align with it.
        run_d  = state_d == S_RUN;
        done_d = state_d == S_RUN && (state_q == S_CSUM || done_q);
        err_d  = state_d == S_ERR;
        busy_d = state_d == S_LEN || state_d == S_DATA || state_d == S_CSUM;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= (AUTORUN != 0) ? S_RUN : S_IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            bc_q    <= '0;
            sum_q   <= '0;
            addr_q  <= '0;
            caddr_q <= '0;
            word_q  <= '0;
            code_q  <= '0;
            wen_q   <= 1'b0;
            run_q   <= AUTORUN != 0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            bc_q    <= bc_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            caddr_q <= caddr_d;
            word_q  <= word_d;
            code_q  <= code_d;
            wen_q   <= wen_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign run          = run_q;
    assign code_w_en    = wen_q;
    assign code_addr_in = caddr_q;
    assign code_in      = code_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = err_q;
endmodule

// File: tb/tb_dibu_code_loader.sv
// tb_dibu_code_loader: randomized image loads checked each cycle against an
// image-position model, plus literal checks of the directed scenarios.
module tb_dibu_code_loader;
    localparam int CW = 16, AW = 8, DP = 16, BPW = CW / 8;
    typedef logic [7:0] bq_t[$];

    logic clk = 0, rst = 1, load_req = 0, load_valid = 0;
    logic [7:0] load_byte = 0;
    logic load_ready, run, code_w_en, busy, done, error;
    logic [AW-1:0] code_addr_in;
    logic [CW-1:0] code_in;
    logic a_ready, a_run, a_wen, a_busy, a_done, a_err;
    logic [AW-1:0] a_addr;
    logic [CW-1:0] a_data;

    dibu_code_loader #(.CODE_W(CW), .CODE_AW(AW), .DEPTH(DP), .AUTORUN(0)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .load_valid(load_valid),
        .load_byte(load_byte), .load_ready(load_ready), .run(run),
        .code_w_en(code_w_en), .code_addr_in(code_addr_in), .code_in(code_in),
        .busy(busy), .done(done), .error(error));

    dibu_code_loader #(.CODE_W(CW), .CODE_AW(AW), .DEPTH(DP), .AUTORUN(1)) u_a (
        .clk(clk), .rst(rst), .load_req(1'b0), .load_valid(1'b0),
        .load_byte(8'd0), .load_ready(a_ready), .run(a_run),
        .code_w_en(a_wen), .code_addr_in(a_addr), .code_in(a_data),
        .busy(a_busy), .done(a_done), .error(a_err));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, wcnt = 0;
    logic [CW-1:0] mem [0:255];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 loading, 2 run, 3 error; m_pos is the byte index within the image.
    int m_phase = 0, m_pos = 0, m_n = 0;
    logic [7:0] m_sum = 0;
    logic [7:0] m_b [0:63];
    bit m_good = 0;
    logic e_wen = 0;
    logic [AW-1:0] e_addr = 0;
    logic [CW-1:0] e_data = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_pos = 0; m_good = 0;
            e_wen = 0; e_addr = 0; e_data = 0;
        end else begin
            e_wen = 0;
            if (load_req) begin
                m_phase = 1; m_pos = 0; m_sum = 0; m_good = 0;
            end else if (m_phase == 1 && load_valid) begin
                m_b[m_pos] = load_byte;
                m_sum = m_sum + load_byte;
                if (m_pos == 0) begin
                    m_n = int'(load_byte);
                    if (m_n == 0 || m_n > DP) m_phase = 3;
                end else if (m_pos <= m_n * BPW) begin
                    if ((m_pos - 1) % BPW == BPW - 1) begin
                        e_wen = 1;
                        e_addr = AW'((m_pos - 1) / BPW);
                        e_data = 0;
                        for (int k = 0; k < BPW; k++)
                            e_data = (e_data << 8) | CW'(m_b[m_pos - BPW + 1 + k]);
                    end
                end else begin
                    m_good = (m_sum == 0);
                    m_phase = m_good ? 2 : 3;
                end
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        chk("code_w_en", 32'(code_w_en), 32'(e_wen));
        chk("code_addr_in", 32'(code_addr_in), 32'(e_addr));
        chk("code_in", 32'(code_in), 32'(e_data));
        chk("run", 32'(run), 32'(m_phase == 2));
        chk("done", 32'(done), 32'(m_phase == 2 && m_good));
        chk("error", 32'(error), 32'(m_phase == 3));
        chk("busy", 32'(busy), 32'(m_phase == 1));
        chk("load_ready", 32'(load_ready), 32'(m_phase == 1 && !load_req));
        if (code_w_en) begin
            mem[code_addr_in] = code_in;
            wcnt++;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic req(input logic v);
        load_req = 1; load_valid = v; load_byte = 8'hEE;
        cyc();
        load_req = 0; load_valid = 0;
    endtask

    task automatic send(input bq_t b, input int mode);
        foreach (b[i]) begin
            if (mode == 2) begin
                load_valid = 0;
                repeat ($urandom_range(0, 2)) cyc();
            end
            load_valid = 1; load_byte = b[i];
            cyc();
            if (mode == 1) begin
                load_valid = 0;
                cyc();
            end
        end
        load_valid = 0;
    endtask

    bq_t img1 = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    bq_t img;
    int base;

    initial begin
        #2 rst = 0;
        cyc();
        chk("rst run", 32'(run), 0);
        chk("rst w_en", 32'(code_w_en), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst ready", 32'(load_ready), 0);
        chk("autorun run", 32'(a_run), 1);
        chk("autorun done", 32'(a_done), 0);
        rst = 1;
        cyc();

        base = wcnt;
        req(0);
        send(img1, 0);
        chk("img1 run", 32'(run), 1);
        chk("img1 done", 32'(done), 1);
        chk("img1 writes", 32'(wcnt - base), 2);
        chk("img1 mem0", 32'(mem[0]), 32'h1234);
        chk("img1 mem1", 32'(mem[1]), 32'hABCD);

        base = wcnt;
        img = img1; img[5] = 8'h41;
        req(0);
        send(img, 0);
        chk("badsum error", 32'(error), 1);
        chk("badsum run", 32'(run), 0);
        chk("badsum done", 32'(done), 0);
        chk("badsum writes", 32'(wcnt - base), 2);

        base = wcnt;
        req(0);
        send('{8'h00, 8'h12, 8'h34}, 0);
        chk("len0 error", 32'(error), 1);
        req(1);
        send('{8'h11, 8'h12, 8'h34}, 0);
        chk("len17 error", 32'(error), 1);
        chk("badlen writes", 32'(wcnt - base), 0);

        base = wcnt;
        req(0);
        send(img1, 1);
        chk("toggle run", 32'(run), 1);
        chk("toggle done", 32'(done), 1);
        chk("toggle writes", 32'(wcnt - base), 2);
        chk("toggle mem1", 32'(mem[1]), 32'hABCD);

        base = wcnt;
        req(0);
        chk("reload run drop", 32'(run), 0);
        send('{8'h01, 8'h00, 8'h07, 8'hF8}, 0);
        chk("reload mem0", 32'(mem[0]), 32'h0007);
        chk("reload run", 32'(run), 1);
        chk("reload writes", 32'(wcnt - base), 1);

        for (int it = 0; it < 60; it++) begin
            int n, cut;
            logic [7:0] s;
            img = {};
            n = int'($urandom_range(1, DP));
            if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(DP + 1, 255));
            img.push_back(8'(n));
            if (n >= 1 && n <= DP)
                for (int j = 0; j < n * BPW; j++) img.push_back(8'($urandom));
            s = 0;
            foreach (img[j]) s = s + img[j];
            img.push_back(8'(0) - s + (($urandom_range(0, 4) == 0) ? 8'd1 : 8'd0));
            cut = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, img.size())) : img.size();
            while (img.size() > cut) void'(img.pop_back());
            req(1'($urandom_range(0, 1)));
            send(img, 2);
            repeat ($urandom_range(0, 2)) cyc();
        end

        req(0);
        send('{8'h02, 8'h12}, 0);
        rst = 0;
        #1;
        chk("midrst w_en", 32'(code_w_en), 0);
        chk("midrst addr", 32'(code_addr_in), 0);
        chk("midrst data", 32'(code_in), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst run", 32'(run), 0);
        chk("midrst ready", 32'(load_ready), 0);
        cyc();
        rst = 1;
        cyc();
        chk("autorun run2", 32'(a_run), 1);
        chk("autorun done2", 32'(a_done), 0);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
